branch_target_buffer: RTL and testbench
=======================================

Name: branch_target_buffer

Overview:
- Direct-mapped branch target buffer that sits directly upstream of the IF-stage PC controller.
- Looks up the current fetch PC combinationally and supplies the prediction inputs the PC controller consumes: predicted-taken, predicted target, and the registered predicted target.
- Trained by resolved branches and jumps from the EX stage.
- Indexes at halfword granularity so compressed (C-extension) instructions get their own entries.

Parameters:
- XLEN, 32, address/data width.
- ENTRIES, 32, number of entries; power of 2, at least 2. IDX_W = log2(ENTRIES).
- TAG_WIDTH, 10, stored tag bits.

Ports:
- i_clk  input  1  clock.
- i_rst_n  input  1  asynchronous active-low reset.
- i_stall  input  1  pipeline stall; holds o_predicted_target_r.
- i_lookup_pc  input  XLEN  fetch PC (the PC controller's o_pc).
- o_hit  output  1  valid entry with tag match, regardless of direction.
- o_predicted_taken  output  1  o_hit and counter MSB set.
- o_predicted_target  output  XLEN  target of the indexed entry; bit0 is always 0.
- o_predicted_target_r  output  XLEN  o_predicted_target registered when !i_stall.
- i_update_valid  input  1  EX resolved a branch or jump this cycle.
- i_update_pc  input  XLEN  PC of the resolved instruction.
- i_update_is_jump  input  1  JAL/JALR (1) or conditional branch (0).
- i_update_taken  input  1  resolved direction.
- i_update_target  input  XLEN  resolved target.
- i_invalidate_all  input  1  clear all entries (fence.i / sfence).

Behaviour:
- Address split: index = pc[IDX_W:1]; tag = pc[IDX_W+TAG_WIDTH:IDX_W+1].
- Entry contents: valid, tag[TAG_WIDTH], target[XLEN-1:1], ctr[1:0].
- Counter encoding: SNT=00, WNT=01, WT=10, ST=11.
- Lookup is purely combinational, 0-cycle latency.
  - o_hit = valid && tag equal.
  - o_predicted_taken = o_hit && ctr[1].
  - o_predicted_target = {target, 1'b0} of the indexed entry (undefined-but-deterministic on miss; consumers gate it with o_predicted_taken).
- Updates, applied at the clock edge when i_update_valid:
  - Hit, conditional branch: ctr saturating +1 if taken, -1 if not taken (saturates at ST and at SNT). Target is overwritten only when taken.
  - Hit, jump: ctr <= ST, target overwritten.
  - Miss, taken: allocate. valid <= 1, tag and target written; ctr <= WT for a branch, ST for a jump. Any aliasing entry is replaced.
  - Miss, not taken: no state change.
- Same-cycle lookup and update to the same index: the lookup returns the pre-update contents. There is no bypass.
- i_invalidate_all: clears every valid bit at the next edge. If asserted in the same cycle as i_update_valid, the invalidate wins and the update is dropped.
- i_stall:
  - Does not block updates; EX gates i_update_valid itself.
  - Freezes o_predicted_target_r.
- Reset (async assert, sync-safe deassert inside the design):
  - All valid bits cleared, ctr <= WNT, tag and target <= 0.
  - o_predicted_target_r <= 0.
  - Combinational outputs are therefore o_hit=0 and o_predicted_taken=0 throughout reset.
  - Reset asserted mid-update discards the update.
- Storage is flops, not BRAM, so lookup meets the same-cycle requirement.

Decomposition:
- Shared cpu package:
  - btb_entry_t struct (valid, tag, target, ctr).
  - ctr localparams SNT/WNT/WT/ST.
  - Helper functions btb_index() and btb_tag() parameterised by IDX_W/TAG_WIDTH.
- Sub-module btb_counter_update: combinational next-ctr function of (ctr, hit, is_jump, taken).
- Table, allocation and the registered target stay in the top module.

Test Plan (ENTRIES=32, TAG_WIDTH=10):
- Reset, then lookup 0x100 -> o_hit=0, o_predicted_taken=0, o_predicted_target_r=0.
- Update pc=0x100, branch, taken, target=0x200; next cycle lookup 0x100 -> hit=1, taken=1, target=0x200; the following unstalled cycle o_predicted_target_r=0x200. Lookup 0x102 (index 1) -> hit=0.
- Not-taken updates at 0x100, starting from WT:
  - 1st -> ctr WNT; lookup gives hit=1, taken=0.
  - 2nd -> ctr SNT.
  - 3rd -> stays SNT.
  - Two taken updates -> WNT, then WT; lookup gives taken=1.
- Alias: 0x100 is valid; taken jump update at 0x140 (same index 0, tag 5 vs 4), target 0x80 ->
  - lookup 0x100 gives hit=0;
  - lookup 0x140 gives taken=1, target=0x80, ctr=ST.
  - A not-taken miss update at 0x180 leaves the 0x140 entry intact.
- Update 0x100 taken in the same cycle as lookup 0x100 (previously miss) -> that cycle shows hit=0; the next cycle shows hit=1.
- Invalidate and reset:
  - i_invalidate_all together with a taken update at 0x300 -> next cycle, lookups of 0x300 and 0x140 both give hit=0.
  - Asserting i_rst_n=0 asynchronously mid-cycle -> o_predicted_target_r=0 and o_predicted_taken=0 immediately, without a clock edge.

Source files
------------

// File: rtl/branch_target_buffer_pkg.sv
// Shared BTB types, counter encodings and PC-to-index/tag helpers.
// Entry layout is sized by BTB_XLEN/BTB_TAG_WIDTH; the top's defaults must match.
package branch_target_buffer_pkg;

    localparam int BTB_XLEN      = 32;
    localparam int BTB_TAG_WIDTH = 10;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    typedef struct packed {
        logic                     valid;
        logic [BTB_TAG_WIDTH-1:0] tag;
        logic [BTB_XLEN-1:1]      target;
        logic [1:0]               ctr;
    } btb_entry_t;

    // Halfword-granular index: pc[idx_w:1].
    function automatic logic [BTB_XLEN-1:0] btb_index(input logic [BTB_XLEN-1:0] pc,
                                                      input int unsigned idx_w);
        return (pc >> 1) & ~({BTB_XLEN{1'b1}} << idx_w);
    endfunction

    // Tag sits immediately above the index: pc[idx_w+tag_w:idx_w+1].
    function automatic logic [BTB_XLEN-1:0] btb_tag(input logic [BTB_XLEN-1:0] pc,
                                                    input int unsigned idx_w,
                                                    input int unsigned tag_w);
        return (pc >> (idx_w + 1)) & ~({BTB_XLEN{1'b1}} << tag_w);
    endfunction

endpackage

// File: rtl/branch_target_buffer_counter_update.sv
// Next 2-bit direction counter for an update, covering hit training and miss allocation.
module btb_counter_update
    import branch_target_buffer_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       hit,
    input  logic       is_jump,
    input  logic       taken,
    output logic [1:0] next_ctr
);

    // Saturating train on hit; allocation strength on taken miss; otherwise unchanged.
    always_comb begin
        next_ctr = ctr;
        if (hit) begin
            if (is_jump) begin
                next_ctr = CTR_ST;
            end else if (taken) begin
                case (ctr)
                    CTR_SNT: next_ctr = CTR_WNT;
                    CTR_WNT: next_ctr = CTR_WT;
                    CTR_WT:  next_ctr = CTR_ST;
                    default: next_ctr = CTR_ST;
                endcase
            end else begin
                case (ctr)
                    CTR_ST:  next_ctr = CTR_WT;
                    CTR_WT:  next_ctr = CTR_WNT;
                    CTR_WNT: next_ctr = CTR_SNT;
                    default: next_ctr = CTR_SNT;
                endcase
            end
        end else if (taken) begin
            next_ctr = is_jump ? CTR_ST : CTR_WT;
        end else begin
            next_ctr = ctr;
        end
    end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped, flop-based branch target buffer with 0-cycle lookup for the IF-stage PC controller.
module branch_target_buffer
    import branch_target_buffer_pkg::*;
#(
    parameter int XLEN      = BTB_XLEN,
    parameter int ENTRIES   = 32,
    parameter int TAG_WIDTH = BTB_TAG_WIDTH
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_stall,
    input  logic [XLEN-1:0] i_lookup_pc,
    output logic            o_hit,
    output logic            o_predicted_taken,
    output logic [XLEN-1:0] o_predicted_target,
    output logic [XLEN-1:0] o_predicted_target_r,
    input  logic            i_update_valid,
    input  logic [XLEN-1:0] i_update_pc,
    input  logic            i_update_is_jump,
    input  logic            i_update_taken,
    input  logic [XLEN-1:0] i_update_target,
    input  logic            i_invalidate_all
);

    localparam int IDX_W = $clog2(ENTRIES);

    logic [1:0]           rst_sync_r;
    logic                 rst_sync_n_s;
    btb_entry_t           table_r [ENTRIES];
    logic [IDX_W-1:0]     lk_idx_s;
    logic [TAG_WIDTH-1:0] lk_tag_s;
    btb_entry_t           lk_entry_s;
    logic [IDX_W-1:0]     up_idx_s;
    logic [TAG_WIDTH-1:0] up_tag_s;
    btb_entry_t           up_entry_s;
    logic                 up_hit_s;
    logic [1:0]           up_ctr_s;

    // Reset synchroniser: asserts asynchronously, releases two edges after i_rst_n rises.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rst_sync_r <= 2'b00;
        end else begin
            rst_sync_r <= {rst_sync_r[0], 1'b1};
        end
    end

    assign rst_sync_n_s = rst_sync_r[1];

    assign lk_idx_s   = IDX_W'(btb_index(i_lookup_pc, IDX_W));
    assign lk_tag_s   = TAG_WIDTH'(btb_tag(i_lookup_pc, IDX_W, TAG_WIDTH));
    assign lk_entry_s = table_r[lk_idx_s];

    assign o_hit              = lk_entry_s.valid && (lk_entry_s.tag == lk_tag_s);
    assign o_predicted_taken  = o_hit && lk_entry_s.ctr[1];
    assign o_predicted_target = {lk_entry_s.target, 1'b0};

    assign up_idx_s   = IDX_W'(btb_index(i_update_pc, IDX_W));
    assign up_tag_s   = TAG_WIDTH'(btb_tag(i_update_pc, IDX_W, TAG_WIDTH));
    assign up_entry_s = table_r[up_idx_s];
    assign up_hit_s   = up_entry_s.valid && (up_entry_s.tag == up_tag_s);

    btb_counter_update u_counter_update (
        .ctr      (up_entry_s.ctr),
        .hit      (up_hit_s),
        .is_jump  (i_update_is_jump),
        .taken    (i_update_taken),
        .next_ctr (up_ctr_s)
    );

    // Table training; invalidate takes priority and drops a coincident update.
    always_ff @(posedge i_clk or negedge rst_sync_n_s) begin
        if (!rst_sync_n_s) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_r[i].valid  <= 1'b0;
                table_r[i].tag    <= {TAG_WIDTH{1'b0}};
                table_r[i].target <= {(XLEN-1){1'b0}};
                table_r[i].ctr    <= CTR_WNT;
            end
        end else if (i_invalidate_all) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_r[i].valid <= 1'b0;
            end
        end else if (i_update_valid) begin
            if (up_hit_s) begin
                table_r[up_idx_s].ctr <= up_ctr_s;
                if (i_update_taken || i_update_is_jump) begin
                    table_r[up_idx_s].target <= i_update_target[XLEN-1:1];
                end
            end else if (i_update_taken) begin
                table_r[up_idx_s].valid  <= 1'b1;
                table_r[up_idx_s].tag    <= up_tag_s;
                table_r[up_idx_s].target <= i_update_target[XLEN-1:1];
                table_r[up_idx_s].ctr    <= up_ctr_s;
            end
        end
    end

    // Registered target for the PC controller, frozen while the pipeline stalls.
    always_ff @(posedge i_clk or negedge rst_sync_n_s) begin
        if (!rst_sync_n_s) begin
            o_predicted_target_r <= {XLEN{1'b0}};
        end else if (!i_stall) begin
            o_predicted_target_r <= o_predicted_target;
        end
    end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Scoreboard bench for branch_target_buffer: expectations queued per cycle, compared at negedge.
module tb_branch_target_buffer;

    localparam int SEL_HIT   = 0;
    localparam int SEL_TAKEN = 1;
    localparam int SEL_TGT   = 2;
    localparam int SEL_TGT_R = 3;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } sb_t;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_stall;
    logic [31:0] i_lookup_pc;
    logic        o_hit;
    logic        o_predicted_taken;
    logic [31:0] o_predicted_target;
    logic [31:0] o_predicted_target_r;
    logic        i_update_valid;
    logic [31:0] i_update_pc;
    logic        i_update_is_jump;
    logic        i_update_taken;
    logic [31:0] i_update_target;
    logic        i_invalidate_all;

    int checks = 0;
    int errors = 0;
    sb_t sb_q[$];

    branch_target_buffer #(.XLEN(32), .ENTRIES(32), .TAG_WIDTH(10)) dut (
        .i_clk                (i_clk),
        .i_rst_n              (i_rst_n),
        .i_stall              (i_stall),
        .i_lookup_pc          (i_lookup_pc),
        .o_hit                (o_hit),
        .o_predicted_taken    (o_predicted_taken),
        .o_predicted_target   (o_predicted_target),
        .o_predicted_target_r (o_predicted_target_r),
        .i_update_valid       (i_update_valid),
        .i_update_pc          (i_update_pc),
        .i_update_is_jump     (i_update_is_jump),
        .i_update_taken       (i_update_taken),
        .i_update_target      (i_update_target),
        .i_invalidate_all     (i_invalidate_all)
    );

    always #5 i_clk = ~i_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input int sel, input logic [31:0] exp);
        sb_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic exp_look(input string tag, input logic hit, input logic taken);
        push({tag, ".hit"}, SEL_HIT, {31'd0, hit});
        push({tag, ".taken"}, SEL_TAKEN, {31'd0, taken});
    endtask

    task automatic next_cycle();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc, input logic uv, input logic [31:0] upc,
                         input logic jmp, input logic tkn, input logic [31:0] tgt,
                         input logic inv, input logic stall);
        i_lookup_pc      = pc;
        i_update_valid   = uv;
        i_update_pc      = upc;
        i_update_is_jump = jmp;
        i_update_taken   = tkn;
        i_update_target  = tgt;
        i_invalidate_all = inv;
        i_stall          = stall;
    endtask

    task automatic look(input logic [31:0] pc);
        drive(pc, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic look_upd(input logic [31:0] pc, input logic [31:0] upc, input logic jmp,
                            input logic tkn, input logic [31:0] tgt);
        drive(pc, 1'b1, upc, jmp, tkn, tgt, 1'b0, 1'b0);
    endtask

    // Drain this cycle's expectations against the settled outputs.
    always @(negedge i_clk) begin
        sb_t e;
        logic [31:0] got;
        while (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            case (e.sel)
                SEL_HIT:   got = {31'd0, o_hit};
                SEL_TAKEN: got = {31'd0, o_predicted_taken};
                SEL_TGT:   got = o_predicted_target;
                default:   got = o_predicted_target_r;
            endcase
            check_eq(e.tag, got, e.exp);
        end
    end

    initial begin
        i_rst_n = 1'b0;
        look(32'h100);
        repeat (2) next_cycle();
        exp_look("rst", 1'b0, 1'b0);
        push("rst.tgt_r", SEL_TGT_R, 32'h0);
        next_cycle();
        i_rst_n = 1'b1;
        repeat (3) next_cycle();

        // First allocation and registered target.
        look_upd(32'h100, 32'h100, 1'b0, 1'b1, 32'h200);
        exp_look("alloc.pre", 1'b0, 1'b0);
        next_cycle(); look(32'h100);
        exp_look("alloc.post", 1'b1, 1'b1);
        push("alloc.tgt", SEL_TGT, 32'h200);
        next_cycle(); look(32'h102);
        exp_look("idx1", 1'b0, 1'b0);
        push("alloc.tgt_r", SEL_TGT_R, 32'h200);

        // Counter training from WT.
        next_cycle(); look_upd(32'h100, 32'h100, 1'b0, 1'b0, 32'h3c);
        exp_look("nt1.pre", 1'b1, 1'b1);
        next_cycle(); look_upd(32'h100, 32'h100, 1'b0, 1'b0, 32'h3c);
        exp_look("ctr.wnt", 1'b1, 1'b0);
        push("nt.tgt_kept", SEL_TGT, 32'h200);
        next_cycle(); look_upd(32'h100, 32'h100, 1'b0, 1'b0, 32'h3c);
        exp_look("ctr.snt", 1'b1, 1'b0);
        next_cycle(); look_upd(32'h100, 32'h100, 1'b0, 1'b1, 32'h200);
        exp_look("ctr.snt_sat", 1'b1, 1'b0);
        next_cycle(); look_upd(32'h100, 32'h100, 1'b0, 1'b1, 32'h200);
        exp_look("ctr.wnt2", 1'b1, 1'b0);
        next_cycle(); look(32'h100);
        exp_look("ctr.wt2", 1'b1, 1'b1);

        // Stall freezes the registered target.
        next_cycle(); drive(32'h102, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        push("stall.pre", SEL_TGT_R, 32'h200);
        next_cycle(); look(32'h102);
        push("stall.hold", SEL_TGT_R, 32'h200);
        next_cycle(); look(32'h102);
        push("stall.release", SEL_TGT_R, 32'h0);

        // Aliasing at index 0.
        next_cycle(); look_upd(32'h140, 32'h140, 1'b1, 1'b1, 32'h80);
        exp_look("alias.pre", 1'b0, 1'b0);
        next_cycle(); look(32'h100);
        exp_look("alias.old", 1'b0, 1'b0);
        next_cycle(); look_upd(32'h140, 32'h180, 1'b0, 1'b0, 32'h44);
        exp_look("alias.new", 1'b1, 1'b1);
        push("alias.tgt", SEL_TGT, 32'h80);
        next_cycle(); look_upd(32'h140, 32'h140, 1'b0, 1'b0, 32'h44);
        exp_look("alias.ntmiss", 1'b1, 1'b1);
        push("alias.ntmiss.tgt", SEL_TGT, 32'h80);
        next_cycle(); look(32'h140);
        exp_look("alias.st", 1'b1, 1'b1);

        // Same-cycle lookup and update: no bypass.
        next_cycle(); look_upd(32'h100, 32'h100, 1'b0, 1'b1, 32'h44);
        exp_look("bypass.same", 1'b0, 1'b0);
        next_cycle(); look(32'h100);
        exp_look("bypass.next", 1'b1, 1'b1);
        push("bypass.tgt", SEL_TGT, 32'h44);

        // Invalidate wins over a coincident update.
        next_cycle(); drive(32'h300, 1'b1, 32'h300, 1'b0, 1'b1, 32'h10, 1'b1, 1'b0);
        next_cycle(); look(32'h300);
        exp_look("inv.300", 1'b0, 1'b0);
        next_cycle(); look(32'h140);
        exp_look("inv.140", 1'b0, 1'b0);
        next_cycle(); look_upd(32'h100, 32'h100, 1'b1, 1'b1, 32'h200);
        exp_look("inv.100", 1'b0, 1'b0);
        next_cycle(); look(32'h100);
        exp_look("rejump", 1'b1, 1'b1);
        next_cycle(); look(32'h100);
        exp_look("prerst", 1'b1, 1'b1);
        push("prerst.tgt_r", SEL_TGT_R, 32'h200);

        // Asynchronous reset mid-cycle.
        next_cycle(); look(32'h100);
        #2;
        i_rst_n = 1'b0;
        #1;
        check_eq("arst.taken", {31'd0, o_predicted_taken}, 32'h0);
        check_eq("arst.hit", {31'd0, o_hit}, 32'h0);
        check_eq("arst.tgt_r", o_predicted_target_r, 32'h0);
        repeat (2) next_cycle();
        check_eq("sb.drained", sb_q.size(), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
